// File: rtl/seg_scan_display.sv
// Multiplexed 4-digit common-anode 7-segment driver with shadow-latched BCD, dp, blanking and overflow.
// Optional leading-zero suppression is enabled by defining LEADING_ZERO_BLANK_EN.
module seg_scan_display #(
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Load,
  input  logic [15:0] BCD,
  input  logic [2:0]  DotLed,
  input  logic        Ovf,
  output logic [7:0]  Seg,
  output logic [3:0]  Dig
);

  localparam int            CW      = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [7:0]    SEG_OFF = {8{SEG_ACTIVE_LOW}};
  localparam logic [3:0]    DIG_OFF = {4{SEG_ACTIVE_LOW}};

  logic [15:0]   bcd_q;
  logic [2:0]    dot_q;
  logic          ovf_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    dig_q, dig_d;

  logic [3:0]    digit_sel;
  logic          dp_sel;
  logic          blank_sel;
  logic [7:0]    seg_act;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    digit_sel = bcd_q[3:0];
    dp_sel    = 1'b0;
    case (idx_q)
      2'd1:    begin digit_sel = bcd_q[7:4];   dp_sel = dot_q[0]; end
      2'd2:    begin digit_sel = bcd_q[11:8];  dp_sel = dot_q[1]; end
      2'd3:    begin digit_sel = bcd_q[15:12]; dp_sel = dot_q[2]; end
      default: begin digit_sel = bcd_q[3:0];   dp_sel = 1'b0;     end
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // zero_from[k]: shadow digits k..3 are all zero; D0 is never suppressed.
  logic [3:0] zero_from;
  logic [1:0] dp_pos;
  assign zero_from[3] = (bcd_q[15:12] == 4'd0);
  assign zero_from[2] = zero_from[3] && (bcd_q[11:8] == 4'd0);
  assign zero_from[1] = zero_from[2] && (bcd_q[7:4] == 4'd0);
  assign zero_from[0] = 1'b0;
  assign dp_pos    = dot_q[2] ? 2'd3 : dot_q[1] ? 2'd2 : dot_q[0] ? 2'd1 : 2'd0;
  assign blank_sel = (idx_q > dp_pos) && zero_from[idx_q];
`else
  assign blank_sel = 1'b0;
`endif

  assign seg_act = ovf_q     ? 8'h40 :
                   blank_sel ? 8'h00 : {dp_sel, seg7(digit_sel)};

  always_comb begin
    cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
    idx_d = (cnt_q == CNT_MAX) ? idx_q + 2'd1 : idx_q;
    seg_d = seg_q;
    dig_d = dig_q;
    // Output latches only at slot start, so a Load mid-slot never tears the digit.
    if (cnt_q == '0) begin
      seg_d = seg_act ^ SEG_OFF;
      dig_d = (4'b0001 << idx_q) ^ DIG_OFF;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK) begin
    if (RST) begin
      bcd_q <= '0;
      dot_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
      idx_q <= '0;
      seg_q <= SEG_OFF;
      dig_q <= DIG_OFF;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      dig_q <= dig_d;
      if (Load) begin
        bcd_q <= BCD;
        dot_q <= DotLed;
        ovf_q <= Ovf;
      end
    end
  end

  assign Seg = seg_q;
  assign Dig = dig_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display: table vectors, hand corner sequences, random stimulus vs model.
module tb_seg_scan_display;

  localparam int SD = 4;

  logic        CLK = 1'b0;
  logic        RST, Load, Ovf;
  logic [15:0] BCD;
  logic [2:0]  DotLed;
  logic [7:0]  Seg;
  logic [3:0]  Dig;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: shadow contents, edges since reset release, and the digit on display.
  logic [15:0] m_bcd;
  logic [2:0]  m_dot;
  logic        m_ovf;
  int          m_k;
  bit          m_valid;
  logic [7:0]  m_seg;
  int          m_digit;

  seg_scan_display #(.SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b1)) dut (
    .CLK(CLK), .RST(RST), .Load(Load), .BCD(BCD),
    .DotLed(DotLed), .Ovf(Ovf), .Seg(Seg), .Dig(Dig)
  );

  always #5 CLK = ~CLK;

  // Active-high segment pattern that digit position pos should show for a given shadow.
  function automatic logic [7:0] ref_seg(input logic [15:0] b, input logic [2:0] d,
                                         input logic o, input int pos);
    logic [7:0] pat [0:9];
    logic [7:0] r;
    int v;
    pat = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
    if (o) return 8'h40;
    v = int'((b >> (4 * pos)) & 16'hF);
    r = (v < 10) ? pat[v] : 8'h00;
    if (pos > 0 && d[pos-1]) r = r | 8'h80;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      int p;
      bit allz;
      p = 0;
      for (int j = 1; j <= 3; j++) if (d[j-1]) p = j;
      allz = 1'b1;
      for (int j = pos; j <= 3; j++) if (((b >> (4 * j)) & 16'hF) != 16'h0) allz = 1'b0;
      if (pos > p && allz) r = 8'h00;
    end
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got seg=%h dig=%b, want seg=%h dig=%b",
               name, got[11:4], got[3:0], exp[11:4], exp[3:0]);
    end
  endtask

  // One clock: drive inputs, advance the model, then compare the pins away from the edge.
  task automatic step(input bit rst, input bit ld, input logic [15:0] b,
                      input logic [2:0] dp, input bit o);
    logic [3:0] oh;
    logic [7:0] e_seg;
    logic [3:0] e_dig;
    RST = rst; Load = ld; BCD = b; DotLed = dp; Ovf = o;
    @(posedge CLK);
    if (rst) begin
      m_bcd = '0; m_dot = '0; m_ovf = 1'b0; m_k = 0; m_valid = 1'b0;
    end else begin
      if (m_k % SD == 0) begin
        m_digit = (m_k / SD) % 4;
        m_seg   = ref_seg(m_bcd, m_dot, m_ovf, m_digit);
        m_valid = 1'b1;
      end
      if (ld) begin
        m_bcd = b; m_dot = dp; m_ovf = o;
      end
      m_k++;
    end
    #1;
    oh    = 4'b0001 << m_digit;
    e_seg = m_valid ? ~m_seg : 8'hFF;
    e_dig = m_valid ? ~oh : 4'hF;
    check("model", {Seg, Dig}, {e_seg, e_dig});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 3'b000, 1'b0);
  endtask

  typedef struct {
    logic [15:0] bcd;
    logic [2:0]  dot;
    logic        ovf;
    logic [31:0] exp;   // active-high {D3, D2, D1, D0}
  } vec_t;

  vec_t tv [10];

  initial begin
    logic [3:0] oh;
    bit found;
    RST = 1'b1; Load = 1'b0; BCD = '0; DotLed = '0; Ovf = 1'b0;
    m_bcd = '0; m_dot = '0; m_ovf = 1'b0; m_k = 0; m_valid = 1'b0; m_seg = '0; m_digit = 0;

    tv[0] = '{16'h1234, 3'b010, 1'b0, 32'h06DB4F66};
    tv[1] = '{16'h0009, 3'b000, 1'b1, 32'h40404040};
    tv[4] = '{16'h0042, 3'b100, 1'b0, 32'hBF3F665B};
    tv[7] = '{16'h8888, 3'b111, 1'b0, 32'hFFFFFF7F};
    tv[8] = '{16'hFFFF, 3'b101, 1'b1, 32'h40404040};
`ifdef LEADING_ZERO_BLANK_EN
    tv[2] = '{16'h0009, 3'b000, 1'b0, 32'h0000006F};
    tv[3] = '{16'h00A5, 3'b000, 1'b0, 32'h0000006D};
    tv[5] = '{16'h0042, 3'b000, 1'b0, 32'h0000665B};
    tv[6] = '{16'h0007, 3'b001, 1'b0, 32'h0000BF07};
    tv[9] = '{16'h0000, 3'b000, 1'b0, 32'h0000003F};
`else
    tv[2] = '{16'h0009, 3'b000, 1'b0, 32'h3F3F3F6F};
    tv[3] = '{16'h00A5, 3'b000, 1'b0, 32'h3F3F006D};
    tv[5] = '{16'h0042, 3'b000, 1'b0, 32'h3F3F665B};
    tv[6] = '{16'h0007, 3'b001, 1'b0, 32'h3F3FBF07};
    tv[9] = '{16'h0000, 3'b000, 1'b0, 32'h3F3F3F3F};
`endif

    // Reset held with Load active: outputs inactive, shadow cleared, first slot is D0 '0'.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 16'h1234, 3'b010, 1'b0);
      check("reset_inactive", {Seg, Dig}, {8'hFF, 4'hF});
    end
    step(1'b0, 1'b0, 16'h0, 3'b000, 1'b0);
    check("first_slot_d0", {Seg, Dig}, {8'hC0, 4'b1110});
    idle(20);

    // Table vectors: load, let every slot refresh, then check one full frame.
    for (int v = 0; v < 10; v++) begin
      step(1'b0, 1'b1, tv[v].bcd, tv[v].dot, tv[v].ovf);
      idle(20);
      for (int c = 0; c < 4 * SD; c++) begin
        step(1'b0, 1'b0, 16'h0, 3'b000, 1'b0);
        oh = 4'b0001 << m_digit;
        check($sformatf("table%0d_d%0d", v, m_digit), {Seg, Dig},
              {~tv[v].exp[8*m_digit +: 8], ~oh});
      end
    end

    // Mid-slot load: D1 keeps '3' to the end of its slot, D2 then shows the new '6'.
    step(1'b0, 1'b1, 16'h1234, 3'b010, 1'b0);
    idle(20);
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (m_valid && m_digit == 1 && (m_k % SD) == 2) found = 1'b1;
      else step(1'b0, 1'b0, 16'h0, 3'b000, 1'b0);
    end
    if (!found) begin
      n_vec++; n_bad++;
      $display("FAIL midslot_sync: got no D1 slot within 64 cycles, want one");
    end
    step(1'b0, 1'b1, 16'h5678, 3'b000, 1'b0);
    check("midslot_hold_a", {Seg, Dig}, {~8'h4F, 4'b1101});
    step(1'b0, 1'b0, 16'h0, 3'b000, 1'b0);
    check("midslot_hold_b", {Seg, Dig}, {~8'h4F, 4'b1101});
    step(1'b0, 1'b0, 16'h0, 3'b000, 1'b0);
    check("midslot_new_d2", {Seg, Dig}, {~8'h7D, 4'b1011});

    // Load held high re-captures every cycle; the last captured value wins.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 16'h0090 + 16'(i), 3'b000, 1'b0);
    idle(24);

    // Random stimulus against the model, including occasional resets and held loads.
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] b;
      b = ($urandom_range(0, 1) == 0) ? 16'($urandom) :
          {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
           4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      if ($urandom_range(0, 3) == 0) b[15:8] = 8'h00;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0, b,
           3'($urandom), $urandom_range(0, 7) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
